// File: rtl/wave_mixer_pkg.sv
// Shared constants and types for the channel mixer.
// Sample/volume widths match the per-channel wave_sound players.
package wave_mixer_pkg;

    localparam int NUM_CHAN  = 8;
    localparam int IDX_W     = 3;
    localparam int SAMPLE_W  = 16;
    localparam int VOL_W     = 8;
    localparam int VOL_SHIFT = 7;
    localparam int TERM_W    = 18;
    localparam int ACC_W     = 21;
    localparam int MIX_W     = 23;
    localparam int PROD_W    = ACC_W + VOL_W + 1;

    localparam logic [VOL_W-1:0] VOL_UNITY = 8'h80;
    localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(NUM_CHAN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_MASTER,
        ST_SAT
    } mix_state_t;

endpackage

// File: rtl/wave_sat.sv
// Combinational clamp of a 23-bit signed mix to a 16-bit signed sample.
// The clip flag marks any value that had to be clamped.
module wave_sat
    import wave_mixer_pkg::*;
(
    input  logic signed [MIX_W-1:0]    din,
    output logic signed [SAMPLE_W-1:0] dout,
    output logic                       clip
);

    localparam logic signed [MIX_W-1:0] MAX_V = MIX_W'(32767);
    localparam logic signed [MIX_W-1:0] MIN_V = -MIX_W'(32768);

    always_comb begin
        dout = din[SAMPLE_W-1:0];
        clip = 1'b0;
        if (din > MAX_V) begin
            dout = 16'sh7FFF;
            clip = 1'b1;
        end else if (din < MIN_V) begin
            dout = -16'sh8000;
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/wave_mixer.sv
// Mixes the per-channel player samples into one output sample with
// per-channel and master volume; one shared multiplier serves both.
module wave_mixer
    import wave_mixer_pkg::*;
(
    input  logic                         I_CLK,
    input  logic                         I_RSTn,
    input  logic [NUM_CHAN*SAMPLE_W-1:0] I_CH_SND,
    input  logic [NUM_CHAN-1:0]          I_CH_EN,
    input  logic                         I_MIX_TRIG,
    input  logic                         I_VOL_WE,
    input  logic [IDX_W-1:0]             I_VOL_CHAN,
    input  logic [VOL_W-1:0]             I_VOL_DATA,
    input  logic [VOL_W-1:0]             I_MASTER_VOL,
    input  logic                         I_CLIP_CLR,
    output logic [SAMPLE_W-1:0]          O_SND,
    output logic                         O_SND_VALID,
    output logic                         O_BUSY,
    output logic                         O_CLIP
);

    mix_state_t state;

    logic [IDX_W-1:0]           idx;
    logic signed [SAMPLE_W-1:0] snd_q [NUM_CHAN];
    logic [NUM_CHAN-1:0]        en_q;
    logic [VOL_W-1:0]           mvol_q;
    logic [VOL_W-1:0]           vol [NUM_CHAN];
    logic signed [ACC_W-1:0]    acc;
    logic signed [MIX_W-1:0]    mix_q;

    logic signed [ACC_W-1:0]    mul_a;
    logic signed [VOL_W:0]      mul_b;
    logic signed [PROD_W-1:0]   prod;
    logic signed [PROD_W-1:0]   prod_sh;
    logic signed [TERM_W-1:0]   term;
    logic signed [SAMPLE_W-1:0] sat_out;
    logic                       sat_clip;

    always_comb begin
        mul_a = ACC_W'(snd_q[idx]);
        mul_b = {1'b0, vol[idx]};
        if (state == ST_MASTER) begin
            mul_a = acc;
            mul_b = {1'b0, mvol_q};
        end
    end

    assign prod    = mul_a * mul_b;
    assign prod_sh = prod >>> VOL_SHIFT;
    assign term    = en_q[idx] ? prod_sh[TERM_W-1:0] : '0;

    wave_sat u_sat (
        .din  (mix_q),
        .dout (sat_out),
        .clip (sat_clip)
    );

    // Writes land at the edge, so an in-flight channel sees the old value.
    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            for (int i = 0; i < NUM_CHAN; i++)
                vol[i] <= VOL_UNITY;
        end else if (I_VOL_WE) begin
            vol[I_VOL_CHAN] <= I_VOL_DATA;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state       <= ST_IDLE;
            idx         <= '0;
            en_q        <= '0;
            mvol_q      <= '0;
            acc         <= '0;
            mix_q       <= '0;
            O_SND       <= '0;
            O_SND_VALID <= 1'b0;
            O_BUSY      <= 1'b0;
            O_CLIP      <= 1'b0;
            for (int i = 0; i < NUM_CHAN; i++)
                snd_q[i] <= '0;
        end else begin
            O_SND_VALID <= 1'b0;
            if (I_CLIP_CLR)
                O_CLIP <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (I_MIX_TRIG) begin
                        for (int i = 0; i < NUM_CHAN; i++)
                            snd_q[i] <= I_CH_SND[i*SAMPLE_W +: SAMPLE_W];
                        en_q   <= I_CH_EN;
                        mvol_q <= I_MASTER_VOL;
                        acc    <= '0;
                        idx    <= '0;
                        O_BUSY <= 1'b1;
                        state  <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc <= acc + ACC_W'(term);
                    idx <= idx + 1'b1;
                    if (idx == LAST_CH)
                        state <= ST_MASTER;
                end
                ST_MASTER: begin
                    mix_q <= prod_sh[MIX_W-1:0];
                    state <= ST_SAT;
                end
                ST_SAT: begin
                    O_SND       <= sat_out;
                    O_SND_VALID <= 1'b1;
                    O_BUSY      <= 1'b0;
                    if (sat_clip)
                        O_CLIP <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_mixer.sv
// Directed bench for wave_mixer: latency, gain, clamp, trigger
// overlap, snapshot coherence and mid-pass reset.
module tb_wave_mixer;

    logic         I_CLK = 1'b0;
    logic         I_RSTn;
    logic [127:0] I_CH_SND;
    logic [7:0]   I_CH_EN;
    logic         I_MIX_TRIG;
    logic         I_VOL_WE;
    logic [2:0]   I_VOL_CHAN;
    logic [7:0]   I_VOL_DATA;
    logic [7:0]   I_MASTER_VOL;
    logic         I_CLIP_CLR;
    logic [15:0]  O_SND;
    logic         O_SND_VALID;
    logic         O_BUSY;
    logic         O_CLIP;

    int n_chk = 0;
    int n_err = 0;
    int lat;
    int nvalid;
    int vcyc [2];

    always #5 I_CLK = ~I_CLK;

    wave_mixer dut (
        .I_CLK        (I_CLK),
        .I_RSTn       (I_RSTn),
        .I_CH_SND     (I_CH_SND),
        .I_CH_EN      (I_CH_EN),
        .I_MIX_TRIG   (I_MIX_TRIG),
        .I_VOL_WE     (I_VOL_WE),
        .I_VOL_CHAN   (I_VOL_CHAN),
        .I_VOL_DATA   (I_VOL_DATA),
        .I_MASTER_VOL (I_MASTER_VOL),
        .I_CLIP_CLR   (I_CLIP_CLR),
        .O_SND        (O_SND),
        .O_SND_VALID  (O_SND_VALID),
        .O_BUSY       (O_BUSY),
        .O_CLIP       (O_CLIP)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic vol_wr(input logic [2:0] ch, input logic [7:0] v);
        @(negedge I_CLK);
        I_VOL_WE   = 1'b1;
        I_VOL_CHAN = ch;
        I_VOL_DATA = v;
        @(negedge I_CLK);
        I_VOL_WE   = 1'b0;
    endtask

    // Returns the cycle of the valid pulse, trigger cycle being 0.
    task automatic run_mix(output int l);
        l = -1;
        @(negedge I_CLK);
        I_MIX_TRIG = 1'b1;
        @(negedge I_CLK);
        I_MIX_TRIG = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (O_SND_VALID) begin
                l = c;
                break;
            end
            @(negedge I_CLK);
        end
    endtask

    initial begin
        I_RSTn       = 1'b0;
        I_CH_SND     = '0;
        I_CH_EN      = '0;
        I_MIX_TRIG   = 1'b0;
        I_VOL_WE     = 1'b0;
        I_VOL_CHAN   = '0;
        I_VOL_DATA   = '0;
        I_MASTER_VOL = 8'h80;
        I_CLIP_CLR   = 1'b0;
        repeat (3) @(negedge I_CLK);
        check("rst_snd", 32'(O_SND), 32'h0);
        check("rst_valid", 32'(O_SND_VALID), 32'h0);
        check("rst_busy", 32'(O_BUSY), 32'h0);
        check("rst_clip", 32'(O_CLIP), 32'h0);
        I_RSTn = 1'b1;

        // 1: eight channels at 0x1000 overflow positive
        I_CH_SND = {8{16'h1000}};
        I_CH_EN  = 8'hFF;
        @(negedge I_CLK);
        I_MIX_TRIG = 1'b1;
        @(negedge I_CLK);
        I_MIX_TRIG = 1'b0;
        check("t1_busy_c1", 32'(O_BUSY), 32'h1);
        repeat (9) @(negedge I_CLK);
        check("t1_busy_c10", 32'(O_BUSY), 32'h1);
        check("t1_novalid_c10", 32'(O_SND_VALID), 32'h0);
        @(negedge I_CLK);
        check("t1_valid_c11", 32'(O_SND_VALID), 32'h1);
        check("t1_busy_c11", 32'(O_BUSY), 32'h0);
        check("t1_snd", 32'(O_SND), 32'h7FFF);
        check("t1_clip", 32'(O_CLIP), 32'h1);
        @(negedge I_CLK);
        check("t1_valid_pulse", 32'(O_SND_VALID), 32'h0);
        check("t1_snd_hold", 32'(O_SND), 32'h7FFF);

        // 2: single channel at half volume
        I_CLIP_CLR = 1'b1;
        @(negedge I_CLK);
        I_CLIP_CLR = 1'b0;
        vol_wr(3'd0, 8'h40);
        I_CH_SND = '0;
        I_CH_SND[15:0] = 16'h0100;
        I_CH_EN  = 8'h01;
        run_mix(lat);
        check("t2_lat", 32'(lat), 32'd11);
        check("t2_snd", 32'(O_SND), 32'h0080);
        check("t2_clip", 32'(O_CLIP), 32'h0);

        // 3: two full-scale negatives, max volumes, clamps negative
        vol_wr(3'd0, 8'hFF);
        vol_wr(3'd1, 8'hFF);
        I_CH_SND = '0;
        I_CH_SND[31:0] = {16'h8000, 16'h8000};
        I_CH_EN  = 8'h03;
        I_MASTER_VOL = 8'hFF;
        run_mix(lat);
        check("t3_lat", 32'(lat), 32'd11);
        check("t3_snd", 32'(O_SND), 32'h8000);
        check("t3_clip", 32'(O_CLIP), 32'h1);
        I_CLIP_CLR = 1'b1;
        @(negedge I_CLK);
        I_CLIP_CLR = 1'b0;
        check("t3_clip_clr", 32'(O_CLIP), 32'h0);

        // 4: retrigger while busy ignored; trigger at cycle 11 accepted
        vol_wr(3'd0, 8'h80);
        vol_wr(3'd1, 8'h80);
        I_MASTER_VOL = 8'h80;
        I_CH_SND = '0;
        I_CH_SND[15:0] = 16'h0123;
        I_CH_EN = 8'h01;
        nvalid = 0;
        vcyc[0] = -1;
        vcyc[1] = -1;
        @(negedge I_CLK);
        I_MIX_TRIG = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge I_CLK);
            I_MIX_TRIG = (c == 5) || (c == 11);
            if (O_SND_VALID) begin
                if (nvalid < 2)
                    vcyc[nvalid] = c;
                nvalid++;
            end
        end
        I_MIX_TRIG = 1'b0;
        check("t4_nvalid", 32'(nvalid), 32'd2);
        check("t4_first", 32'(vcyc[0]), 32'd11);
        check("t4_second", 32'(vcyc[1]), 32'd22);
        check("t4_snd", 32'(O_SND), 32'h0123);

        // 5: inputs change mid-pass, output follows the snapshot
        I_CH_SND = '0;
        I_CH_SND[15:0] = 16'h0100;
        I_CH_EN = 8'h01;
        @(negedge I_CLK);
        I_MIX_TRIG = 1'b1;
        @(negedge I_CLK);
        I_MIX_TRIG = 1'b0;
        repeat (2) @(negedge I_CLK);
        I_CH_SND[15:0] = 16'h7FFF;
        I_CH_EN = 8'hFF;
        repeat (8) @(negedge I_CLK);
        check("t5_valid", 32'(O_SND_VALID), 32'h1);
        check("t5_snd", 32'(O_SND), 32'h0100);

        // 6: reset mid-pass aborts and restores unity volumes
        vol_wr(3'd0, 8'h40);
        I_CH_SND = '0;
        I_CH_SND[15:0] = 16'h0200;
        I_CH_EN = 8'h01;
        @(negedge I_CLK);
        I_MIX_TRIG = 1'b1;
        @(negedge I_CLK);
        I_MIX_TRIG = 1'b0;
        repeat (5) @(negedge I_CLK);
        I_RSTn = 1'b0;
        @(negedge I_CLK);
        check("t6_rst_snd", 32'(O_SND), 32'h0);
        check("t6_rst_busy", 32'(O_BUSY), 32'h0);
        check("t6_rst_valid", 32'(O_SND_VALID), 32'h0);
        I_RSTn = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge I_CLK);
            if (O_SND_VALID)
                nvalid++;
        end
        check("t6_no_valid", 32'(nvalid), 32'd0);
        run_mix(lat);
        check("t6_lat", 32'(lat), 32'd11);
        check("t6_snd", 32'(O_SND), 32'h0200);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
